// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART.
package uart_pkg;

    // Dividers below this value leave too few cycles per bit for mid-bit sampling
    localparam int MIN_DIV = 3;
    // Number of idle bit periods inserted after a divider change
    localparam int GUARD_BITS = 15;

    // Status register bit positions
    localparam int STAT_RX_AVAIL   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_TX_IDLE    = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_FRAME_ERR  = 4;
    localparam int STAT_PARITY_ERR = 5;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b10,
        PAR_ODD  = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_GUARD
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
    endfunction

    // Both 00 and 01 mean "no parity"
    function automatic parity_e decode_parity(input logic [1:0] p);
        return p[1] ? (p[0] ? PAR_ODD : PAR_EVEN) : PAR_NONE;
    endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// Peripheral-bus register interface of the buffered UART.
interface uart_buffered_if;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_cfg_we;
    logic [5:0]  reg_cfg_di;
    logic [5:0]  reg_cfg_do;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_re;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;
    logic        reg_stat_re;
    logic [7:0]  reg_stat_do;

    modport master (
        output reg_div_we, reg_div_di, reg_cfg_we, reg_cfg_di,
               reg_dat_we, reg_dat_di, reg_dat_re, reg_stat_re,
        input  reg_div_do, reg_cfg_do, reg_dat_do, reg_dat_wait, reg_stat_do
    );

    modport slave (
        input  reg_div_we, reg_div_di, reg_cfg_we, reg_cfg_di,
               reg_dat_we, reg_dat_di, reg_dat_re, reg_stat_re,
        output reg_div_do, reg_cfg_do, reg_dat_do, reg_dat_wait, reg_stat_do
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with head-of-queue data visible combinationally.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: TX/RX FIFOs, configurable framing, sticky error flags and interrupt.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 608,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    uart_buffered_if.slave  bus,
    output logic            ser_tx,
    input  logic            ser_rx,
    output logic            irq
);
    logic [31:0]          div_reg;
    logic [5:0]           cfg_reg;
    parity_e              cfg_parity;
    logic                 div_write;
    logic                 tx_full, tx_empty, tx_pop, tx_idle;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_head;
    tx_state_e            tx_state;
    logic [31:0]          tx_cnt, tx_div;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_bit, tx_par_en, tx_stop2, guard_req;
    logic                 rx_s1, rx_s2, rx_armed;
    rx_state_e            rx_state;
    logic [31:0]          rx_cnt, rx_div, rx_half;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift, rx_push_data;
    parity_e              rx_parity;
    logic                 rx_push, frame_set, parity_set, overrun_set;
    logic                 overrun, frame_err, parity_err;
    logic [7:0]           stat;
    logic                 unused_dat_bits;

    assign cfg_parity      = decode_parity(cfg_reg[1:0]);
    assign div_write       = |bus.reg_div_we;
    assign unused_dat_bits = &{1'b0, bus.reg_dat_di[31:DATA_BITS]};

    // Divider (byte-writable) and configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= 32'(DEFAULT_DIV);
            cfg_reg <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.reg_div_we[i]) div_reg[8*i +: 8] <= bus.reg_div_di[8*i +: 8];
            if (bus.reg_cfg_we) cfg_reg <= bus.reg_cfg_di;
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push(bus.reg_dat_we && !tx_full), .push_data(bus.reg_dat_di[DATA_BITS-1:0]),
        .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push(rx_push), .push_data(rx_push_data),
        .pop(bus.reg_dat_re), .head(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty && !guard_req;
    assign tx_idle = tx_empty && (tx_state == TX_IDLE) && !guard_req;

    // TX framer; divider and framing are latched when a frame (or guard gap) begins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            ser_tx     <= 1'b1;
            tx_cnt     <= '0;
            tx_div     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par_bit <= 1'b0;
            tx_par_en  <= 1'b0;
            tx_stop2   <= 1'b0;
            guard_req  <= 1'b0;
        end else begin
            if (div_write) guard_req <= 1'b1;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                if (guard_req) begin
                    tx_state  <= TX_GUARD;
                    tx_div    <= eff_div(div_reg);
                    guard_req <= div_write;
                end else if (!tx_empty) begin
                    tx_state   <= TX_START;
                    ser_tx     <= 1'b0;
                    tx_shift   <= tx_head;
                    tx_div     <= eff_div(div_reg);
                    tx_par_en  <= (cfg_parity != PAR_NONE);
                    tx_par_bit <= (^tx_head) ^ (cfg_parity == PAR_ODD);
                    tx_stop2   <= cfg_reg[2];
                end
            end else if (tx_cnt != tx_div) begin
                tx_cnt <= tx_cnt + 32'd1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        ser_tx   <= tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == 4'(DATA_BITS - 1)) begin
                            tx_bit   <= '0;
                            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                            ser_tx   <= tx_par_en ? tx_par_bit : 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            ser_tx   <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        ser_tx   <= 1'b1;
                    end
                    TX_STOP: begin
                        if (tx_stop2 && tx_bit == 4'd0) tx_bit   <= 4'd1;
                        else                            tx_state <= TX_IDLE;
                    end
                    TX_GUARD: begin
                        if (tx_bit == 4'(GUARD_BITS - 1)) tx_state <= TX_IDLE;
                        else                              tx_bit   <= tx_bit + 4'd1;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= ser_rx;
            rx_s2 <= rx_s1;
        end
    end

    assign rx_half = (rx_div >> 1) + {31'd0, rx_div[0]};

    // RX deframer; after a frame the line must go high again before a new start is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_div       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_parity    <= PAR_NONE;
            rx_armed     <= 1'b0;
            rx_push      <= 1'b0;
            rx_push_data <= '0;
            frame_set    <= 1'b0;
            parity_set   <= 1'b0;
        end else begin
            rx_push    <= 1'b0;
            frame_set  <= 1'b0;
            parity_set <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (rx_s2) begin
                        rx_armed <= 1'b1;
                    end else if (rx_armed) begin
                        rx_state  <= RX_START;
                        rx_div    <= eff_div(div_reg);
                        rx_parity <= cfg_parity;
                    end
                end
                RX_START: begin
                    if (rx_cnt == rx_half - 32'd1) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 32'd1;
                    end
                end
                default: begin
                    if (rx_cnt != rx_div) begin
                        rx_cnt <= rx_cnt + 32'd1;
                    end else begin
                        rx_cnt <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                            rx_bit   <= rx_bit + 4'd1;
                            if (rx_bit == 4'(DATA_BITS - 1))
                                rx_state <= (rx_parity == PAR_NONE) ? RX_STOP : RX_PARITY;
                        end else if (rx_state == RX_PARITY) begin
                            parity_set <= ((^rx_shift) ^ (rx_parity == PAR_ODD)) != rx_s2;
                            rx_state   <= RX_STOP;
                        end else begin
                            rx_push      <= 1'b1;
                            rx_push_data <= rx_shift;
                            frame_set    <= !rx_s2;
                            rx_armed     <= 1'b0;
                            rx_state     <= RX_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign overrun_set = rx_push && rx_full && !bus.reg_dat_re;

    // Sticky error flags; a new error in the same cycle as a status read is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= overrun_set | (overrun    & ~bus.reg_stat_re);
            frame_err  <= frame_set   | (frame_err  & ~bus.reg_stat_re);
            parity_err <= parity_set  | (parity_err & ~bus.reg_stat_re);
        end
    end

    // Status word assembly
    always_comb begin
        stat                  = '0;
        stat[STAT_RX_AVAIL]   = !rx_empty;
        stat[STAT_TX_FULL]    = tx_full;
        stat[STAT_TX_IDLE]    = tx_idle;
        stat[STAT_OVERRUN]    = overrun;
        stat[STAT_FRAME_ERR]  = frame_err;
        stat[STAT_PARITY_ERR] = parity_err;
    end

    // Registered interrupt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= (cfg_reg[3] & !rx_empty) | (cfg_reg[4] & tx_empty) |
                        (cfg_reg[5] & (overrun | frame_err | parity_err));
    end

    assign bus.reg_div_do   = div_reg;
    assign bus.reg_cfg_do   = cfg_reg;
    assign bus.reg_dat_do   = rx_empty ? 32'hFFFF_FFFF : {{(32-DATA_BITS){1'b0}}, rx_head};
    assign bus.reg_dat_wait = tx_full;
    assign bus.reg_stat_do  = stat;
endmodule

// File: tb/tb_uart_buffered.sv
// Directed self-checking bench for uart_buffered.
module tb_uart_buffered;
    logic clk = 1'b0;
    logic rst;
    logic ser_tx;
    logic ser_rx;
    logic irq;
    logic loopback;
    logic rx_line;
    int   checks = 0;
    int   errors = 0;

    uart_buffered_if bus();

    uart_buffered #(.DEFAULT_DIV(608), .DATA_BITS(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .ser_tx(ser_tx), .ser_rx(ser_rx), .irq(irq)
    );

    assign ser_rx = loopback ? ser_tx : rx_line;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic write_div(input logic [31:0] v);
        @(negedge clk); bus.reg_div_we = 4'hF; bus.reg_div_di = v;
        @(negedge clk); bus.reg_div_we = 4'h0;
    endtask

    task automatic write_cfg(input logic [5:0] v);
        @(negedge clk); bus.reg_cfg_we = 1'b1; bus.reg_cfg_di = v;
        @(negedge clk); bus.reg_cfg_we = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        @(negedge clk); bus.reg_dat_we = 1'b1; bus.reg_dat_di = {24'h0, v};
        @(negedge clk); bus.reg_dat_we = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk); bus.reg_dat_re = 1'b1;
        @(negedge clk); bus.reg_dat_re = 1'b0;
    endtask

    task automatic read_stat();
        @(negedge clk); bus.reg_stat_re = 1'b1;
        @(negedge clk); bus.reg_stat_re = 1'b0;
    endtask

    // Drive one frame on rx_line with an 8-cycle bit period, then idle high
    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop_bit);
        @(negedge clk);
        rx_line = 1'b0; repeat (8) @(negedge clk);
        for (int b = 0; b < 8; b++) begin rx_line = d[b]; repeat (8) @(negedge clk); end
        if (par_en) begin rx_line = par_bit; repeat (8) @(negedge clk); end
        rx_line = stop_bit; repeat (8) @(negedge clk);
        rx_line = 1'b1; repeat (16) @(negedge clk);
    endtask

    // Decode one frame from ser_tx by sampling mid-bit; returns at mid-stop
    task automatic capture_tx(input int period, output logic [7:0] d, output bit ok);
        int n;
        d = '0; ok = 1'b0; n = 0;
        @(negedge clk);
        while (ser_tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) return;
        repeat (period / 2) @(negedge clk);
        if (ser_tx !== 1'b0) return;
        for (int b = 0; b < 8; b++) begin repeat (period) @(negedge clk); d[b] = ser_tx; end
        repeat (period) @(negedge clk);
        ok = (ser_tx === 1'b1);
    endtask

    task automatic test_reset();
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_ser_tx: got %b, want 1", ser_tx); end
        checks++; if (bus.reg_div_do !== 32'd608) begin errors++; $display("[TB] FAIL reset_div: got %0d, want 608", bus.reg_div_do); end
        checks++; if (bus.reg_cfg_do !== 6'h00) begin errors++; $display("[TB] FAIL reset_cfg: got %h, want 00", bus.reg_cfg_do); end
        checks++; if (bus.reg_stat_do !== 8'h04) begin errors++; $display("[TB] FAIL reset_stat: got %h, want 04", bus.reg_stat_do); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b, want 0", irq); end
        checks++; if (bus.reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_dat: got %h, want ffffffff", bus.reg_dat_do); end
    endtask

    task automatic test_tx_basic();
        logic [9:0] frame;
        int n, low_run;
        bit high_seen;
        frame = {1'b1, 8'h55, 1'b0};
        write_div(32'd15);
        write_cfg(6'h00);
        push_byte(8'h55);
        n = 0;
        while (ser_tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 2000) begin
            errors++; $display("[TB] FAIL tx_start_timeout: ser_tx=%b after %0d cycles, want 0", ser_tx, n);
        end else begin
            low_run = 0; high_seen = 1'b0;
            for (int i = 0; i < 160; i++) begin
                if (!high_seen) begin
                    if (ser_tx === 1'b0) low_run++;
                    else high_seen = 1'b1;
                end
                if (i % 16 == 8) begin
                    checks++;
                    if (ser_tx !== frame[i/16]) begin
                        errors++; $display("[TB] FAIL tx_bit%0d: got %b, want %b", i/16, ser_tx, frame[i/16]);
                    end
                end
                @(negedge clk);
            end
            checks++; if (low_run != 16) begin errors++; $display("[TB] FAIL tx_start_len: got %0d cycles, want 16", low_run); end
        end
        repeat (20) @(negedge clk);
        checks++; if (bus.reg_stat_do !== 8'h04) begin errors++; $display("[TB] FAIL tx_idle_stat: got %h, want 04", bus.reg_stat_do); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [10];
        bit okv [10];
        bit wait_seen [10];
        logic full_flag;
        full_flag = 1'b0;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 10; k++) capture_tx(16, got[k], okv[k]);
            end
            begin
                int n;
                for (int i = 0; i < 10; i++) begin
                    bus.reg_dat_we = 1'b1; bus.reg_dat_di = 32'(8'h31 + 8'(i));
                    n = 0; wait_seen[i] = 1'b0;
                    while (bus.reg_dat_wait === 1'b1 && n < 400) begin
                        wait_seen[i] = 1'b1; full_flag = bus.reg_stat_do[1];
                        @(negedge clk); n++;
                    end
                    if (n >= 400) begin errors++; $display("[TB] FAIL wait_timeout: byte %0d wait=%b, want 0", i, bus.reg_dat_wait); end
                    @(negedge clk);
                end
                bus.reg_dat_we = 1'b0;
            end
        join
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (wait_seen[i] !== (i == 9)) begin errors++; $display("[TB] FAIL wait_byte%0d: got %b, want %b", i, wait_seen[i], (i == 9)); end
            checks++;
            if (!okv[i] || got[i] !== 8'h31 + 8'(i)) begin
                errors++; $display("[TB] FAIL b2b_byte%0d: got %h (framing ok=%b), want %h", i, got[i], okv[i], 8'h31 + 8'(i));
            end
        end
        checks++; if (full_flag !== 1'b1) begin errors++; $display("[TB] FAIL stat_tx_full: got %b, want 1", full_flag); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp [3];
        int n;
        exp = '{8'h00, 8'hFF, 8'hA5};
        write_div(32'd7);
        write_cfg(6'h06);
        loopback = 1'b1;
        for (int k = 0; k < 3; k++) push_byte(exp[k]);
        n = 0;
        while (bus.reg_stat_do[2] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin errors++; $display("[TB] FAIL loop_timeout: tx_idle=%b, want 1", bus.reg_stat_do[2]); end
        repeat (30) @(negedge clk);
        checks++; if (bus.reg_stat_do !== 8'h05) begin errors++; $display("[TB] FAIL loop_stat: got %h, want 05", bus.reg_stat_do); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.reg_dat_do !== {24'h0, exp[k]}) begin errors++; $display("[TB] FAIL loop_byte%0d: got %h, want %h", k, bus.reg_dat_do, exp[k]); end
            pop_rx();
        end
        checks++; if (bus.reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL loop_empty: got %h, want ffffffff", bus.reg_dat_do); end
        loopback = 1'b0;
    endtask

    task automatic test_rx_errors();
        write_cfg(6'h23);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.reg_stat_do !== 8'h15) begin errors++; $display("[TB] FAIL frame_err_stat: got %h, want 15", bus.reg_stat_do); end
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL err_irq: got %b, want 1", irq); end
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.reg_stat_do !== 8'h35) begin errors++; $display("[TB] FAIL parity_err_stat: got %h, want 35", bus.reg_stat_do); end
        read_stat();
        checks++; if (bus.reg_stat_do !== 8'h05) begin errors++; $display("[TB] FAIL stat_clear: got %h, want 05", bus.reg_stat_do); end
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b, want 0", irq); end
        checks++; if (bus.reg_dat_do !== 32'h3C) begin errors++; $display("[TB] FAIL err_byte0: got %h, want 3c", bus.reg_dat_do); end
        pop_rx();
        checks++; if (bus.reg_dat_do !== 32'h81) begin errors++; $display("[TB] FAIL err_byte1: got %h, want 81", bus.reg_dat_do); end
        pop_rx();
    endtask

    task automatic test_overrun();
        write_cfg(6'h00);
        for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        checks++; if (bus.reg_stat_do[3] !== 1'b0) begin errors++; $display("[TB] FAIL overrun_early: got %b, want 0", bus.reg_stat_do[3]); end
        send_frame(8'h48, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.reg_stat_do[3] !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b, want 1", bus.reg_stat_do[3]); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.reg_dat_do !== 32'(8'h40 + 8'(i))) begin errors++; $display("[TB] FAIL ovr_byte%0d: got %h, want %h", i, bus.reg_dat_do, 8'h40 + 8'(i)); end
            pop_rx();
        end
        checks++; if (bus.reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL ovr_empty: got %h, want ffffffff", bus.reg_dat_do); end
    endtask

    task automatic test_reset_midframe();
        int n;
        push_byte(8'h00);
        n = 0;
        while (ser_tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        repeat (18) @(negedge clk);
        checks++; if (ser_tx !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_tx: got %b, want 0", ser_tx); end
        rst = 1'b1; rx_line = 1'b0;
        #1;
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_ser_tx: got %b, want 1", ser_tx); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk); rx_line = 1'b1;
        repeat (400) @(negedge clk);
        checks++; if (bus.reg_div_do !== 32'd608) begin errors++; $display("[TB] FAIL rst_div: got %0d, want 608", bus.reg_div_do); end
        checks++; if (bus.reg_stat_do !== 8'h04) begin errors++; $display("[TB] FAIL rst_stat: got %h, want 04", bus.reg_stat_do); end
        checks++; if (bus.reg_dat_do !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL glitch_rx: got %h, want ffffffff", bus.reg_dat_do); end
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("[TB] FAIL rst_tx_idle: got %b, want 1", ser_tx); end
    endtask

    initial begin
        rst = 1'b1; loopback = 1'b0; rx_line = 1'b1;
        bus.reg_div_we = '0; bus.reg_div_di = '0; bus.reg_cfg_we = 1'b0; bus.reg_cfg_di = '0;
        bus.reg_dat_we = 1'b0; bus.reg_dat_di = '0; bus.reg_dat_re = 1'b0; bus.reg_stat_re = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] starting directed tests");
        test_reset();
        test_tx_basic();
        test_back_to_back();
        test_loopback();
        test_rx_errors();
        test_overrun();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
